// File: rtl/tdc_echo_select.sv
// Echo selector: collects TDC echo beats into frames and emits one record per frame
// holding the strongest eligible echo, the beat count, the last Onum and status flags.
module tdc_echo_select #(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CNT_W   = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [14:0]      TDC_Odata,
    input  logic [4:0]       TDC_Oint,
    input  logic [1:0]       TDC_Onum,
    input  logic             TDC_Olast,
    input  logic             TDC_Ovalid,
    output logic             TDC_Oready,
    input  logic [4:0]       cfg_min_int,
    output logic [14:0]      res_depth,
    output logic [4:0]       res_int,
    output logic [CNT_W-1:0] res_cnt,
    output logic [1:0]       res_num,
    output logic [1:0]       res_flags,
    output logic             res_valid,
    input  logic             res_ready
);

    localparam int unsigned IdleW = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

    typedef enum logic [1:0] {StIdle, StCollect, StOutput} state_t;

    state_t           state_q, state_d;
    logic [IdleW-1:0] idle_q, idle_d;
    logic [14:0]      depth_q, depth_d;
    logic [4:0]       int_q, int_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       num_q, num_d;
    logic [1:0]       flags_q, flags_d;
    logic             found_q, found_d;
    logic             valid_q;

    logic             accept;
    logic             first;
    logic [14:0]      b_depth;
    logic [4:0]       b_int;
    logic [CNT_W-1:0] b_cnt;
    logic             b_found;

    assign TDC_Oready = (state_q != StOutput);
    assign accept     = TDC_Ovalid && TDC_Oready && !rst;
    assign first      = (state_q == StIdle);

    // The first beat of a frame starts from a clean accumulator.
    assign b_depth = first ? '0 : depth_q;
    assign b_int   = first ? '0 : int_q;
    assign b_cnt   = first ? '0 : cnt_q;
    assign b_found = first ? 1'b0 : found_q;

    always_comb begin
        state_d = state_q;
        idle_d  = idle_q;
        depth_d = depth_q;
        int_d   = int_q;
        cnt_d   = cnt_q;
        num_d   = num_q;
        flags_d = flags_q;
        found_d = found_q;
        if (accept) begin
            idle_d  = '0;
            cnt_d   = (b_cnt == CntMax) ? b_cnt : b_cnt + 1'b1;
            num_d   = TDC_Onum;
            depth_d = b_depth;
            int_d   = b_int;
            found_d = b_found;
            flags_d = first ? 2'b00 : flags_q;
            // Strictly greater keeps the earlier echo on ties.
            if ((TDC_Oint >= cfg_min_int) && (!b_found || (TDC_Oint > b_int))) begin
                depth_d = TDC_Odata;
                int_d   = TDC_Oint;
                found_d = 1'b1;
            end
            if (TDC_Olast) begin
                state_d    = StOutput;
                flags_d[0] = !found_d;
            end else begin
                state_d = StCollect;
            end
        end else if (state_q == StCollect) begin
            if (idle_q == IdleW'(TIMEOUT)) begin
                state_d = StOutput;
                flags_d = {1'b1, !found_q};
            end else begin
                idle_d = idle_q + 1'b1;
            end
        end else if ((state_q == StOutput) && res_ready) begin
            state_d = StIdle;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            idle_q  <= '0;
            depth_q <= '0;
            int_q   <= '0;
            cnt_q   <= '0;
            num_q   <= '0;
            flags_q <= '0;
            found_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idle_q  <= idle_d;
            depth_q <= depth_d;
            int_q   <= int_d;
            cnt_q   <= cnt_d;
            num_q   <= num_d;
            flags_q <= flags_d;
            found_q <= found_d;
            valid_q <= (state_d == StOutput);
        end
    end

    assign res_depth = depth_q;
    assign res_int   = int_q;
    assign res_cnt   = cnt_q;
    assign res_num   = num_q;
    assign res_flags = flags_q;
    assign res_valid = valid_q;

endmodule

// File: tb/tb_tdc_echo_select.sv
// Directed self-checking bench for tdc_echo_select (default parameters).
module tb_tdc_echo_select;

    logic        clk = 1'b0;
    logic        rst;
    logic [14:0] TDC_Odata;
    logic [4:0]  TDC_Oint;
    logic [1:0]  TDC_Onum;
    logic        TDC_Olast;
    logic        TDC_Ovalid;
    logic        TDC_Oready;
    logic [4:0]  cfg_min_int;
    logic [14:0] res_depth;
    logic [4:0]  res_int;
    logic [2:0]  res_cnt;
    logic [1:0]  res_num;
    logic [1:0]  res_flags;
    logic        res_valid;
    logic        res_ready;

    int n_cmp = 0;
    int n_bad = 0;

    always #2 clk = ~clk;

    tdc_echo_select #(.TIMEOUT(64), .CNT_W(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .TDC_Odata   (TDC_Odata),
        .TDC_Oint    (TDC_Oint),
        .TDC_Onum    (TDC_Onum),
        .TDC_Olast   (TDC_Olast),
        .TDC_Ovalid  (TDC_Ovalid),
        .TDC_Oready  (TDC_Oready),
        .cfg_min_int (cfg_min_int),
        .res_depth   (res_depth),
        .res_int     (res_int),
        .res_cnt     (res_cnt),
        .res_num     (res_num),
        .res_flags   (res_flags),
        .res_valid   (res_valid),
        .res_ready   (res_ready)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic beat(input logic [14:0] d, input logic [4:0] i, input logic [1:0] n,
                        input logic l);
        TDC_Odata  = d;
        TDC_Oint   = i;
        TDC_Onum   = n;
        TDC_Olast  = l;
        TDC_Ovalid = 1'b1;
        tick();
        TDC_Ovalid = 1'b0;
    endtask

    task automatic chk_rec(input string tag, input logic [14:0] d, input logic [4:0] i,
                           input logic [2:0] c, input logic [1:0] n, input logic [1:0] f);
        chk({tag, "_valid"}, 32'(res_valid), 32'd1);
        chk({tag, "_depth"}, 32'(res_depth), 32'(d));
        chk({tag, "_int"},   32'(res_int),   32'(i));
        chk({tag, "_cnt"},   32'(res_cnt),   32'(c));
        chk({tag, "_num"},   32'(res_num),   32'(n));
        chk({tag, "_flags"}, 32'(res_flags), 32'(f));
        chk({tag, "_ready"}, 32'(TDC_Oready), 32'd0);
    endtask

    initial begin
        logic [4:0] ints [9];
        ints = '{5'd1, 5'd5, 5'd8, 5'd2, 5'd8, 5'd9, 5'd3, 5'd9, 5'd4};

        rst = 1'b1; TDC_Odata = '0; TDC_Oint = '0; TDC_Onum = '0; TDC_Olast = 1'b0;
        TDC_Ovalid = 1'b0; cfg_min_int = 5'd2; res_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_ready", 32'(TDC_Oready), 32'd1);
        chk("rst_valid", 32'(res_valid), 32'd0);
        chk("rst_depth", 32'(res_depth), 32'd0);
        chk("rst_int",   32'(res_int),   32'd0);
        chk("rst_cnt",   32'(res_cnt),   32'd0);
        chk("rst_num",   32'(res_num),   32'd0);
        chk("rst_flags", 32'(res_flags), 32'd0);

        // Three beats, tie at 9 keeps the earlier beat.
        beat(15'd100, 5'd4, 2'd1, 1'b0);
        chk("t1_pre_valid", 32'(res_valid), 32'd0);
        beat(15'd200, 5'd9, 2'd2, 1'b0);
        beat(15'd300, 5'd9, 2'd3, 1'b1);
        chk_rec("t1", 15'd200, 5'd9, 3'd1 + 3'd2, 2'd3, 2'b00);
        tick();
        chk("t1_done_valid", 32'(res_valid), 32'd0);
        chk("t1_done_ready", 32'(TDC_Oready), 32'd1);

        // Single ineligible beat.
        cfg_min_int = 5'd5;
        beat(15'h1FFC, 5'd3, 2'd0, 1'b1);
        chk_rec("t2", 15'd0, 5'd0, 3'd1, 2'd0, 2'b01);
        tick();

        // Timeout close after two beats.
        cfg_min_int = 5'd0;
        res_ready = 1'b0;
        beat(15'd10, 5'd5, 2'd0, 1'b0);
        beat(15'd20, 5'd7, 2'd1, 1'b0);
        repeat (64) tick();
        chk("t3_valid_at64", 32'(res_valid), 32'd0);
        chk("t3_ready_at64", 32'(TDC_Oready), 32'd1);
        tick();
        chk_rec("t3", 15'd20, 5'd7, 3'd2, 2'd1, 2'b10);

        // Backpressure with the next frame's beat waiting.
        TDC_Odata = 15'd55; TDC_Oint = 5'd6; TDC_Onum = 2'd2; TDC_Olast = 1'b1;
        TDC_Ovalid = 1'b1;
        repeat (10) tick();
        chk_rec("t5_hold", 15'd20, 5'd7, 3'd2, 2'd1, 2'b10);
        res_ready = 1'b1;
        tick();
        chk("t5_release_valid", 32'(res_valid), 32'd0);
        chk("t5_release_ready", 32'(TDC_Oready), 32'd1);
        res_ready = 1'b0;
        tick();
        TDC_Ovalid = 1'b0;
        chk_rec("t5_next", 15'd55, 5'd6, 3'd1, 2'd2, 2'b00);
        res_ready = 1'b1;
        tick();

        // Nine beats: count saturates at 7, first int-9 beat (depth 51) wins.
        cfg_min_int = 5'd3;
        for (int k = 0; k < 9; k++) begin
            beat(15'(k * 10 + 1), ints[k], 2'(k), k == 8);
        end
        chk_rec("t4", 15'd51, 5'd9, 3'd7, 2'd0, 2'b00);
        tick();

        // Reset mid-frame, with a beat offered during reset.
        beat(15'd77, 5'd10, 2'd0, 1'b0);
        beat(15'd88, 5'd12, 2'd1, 1'b0);
        rst = 1'b1;
        beat(15'd99, 5'd20, 2'd3, 1'b1);
        rst = 1'b0;
        chk("t6_rst_cnt",   32'(res_cnt),   32'd0);
        chk("t6_rst_depth", 32'(res_depth), 32'd0);
        chk("t6_rst_ready", 32'(TDC_Oready), 32'd1);
        repeat (3) tick();
        chk("t6_no_record", 32'(res_valid), 32'd0);
        beat(15'd5, 5'd3, 2'd1, 1'b0);
        chk("t6_cnt_first", 32'(res_cnt), 32'd1);
        beat(15'd6, 5'd2, 2'd2, 1'b1);
        chk_rec("t6", 15'd5, 5'd3, 3'd2, 2'd2, 2'b00);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/tdc_echo_select.md
TDC_ECHO_SELECT -- requirements
Module: tdc_echo_select

Interface
REQ-001 Parameter TIMEOUT, default 64: idle cycles after last accepted beat before a partial frame is force-closed.
REQ-002 Parameter CNT_W, default 3: width of the echo counter; it saturates at 2^CNT_W-1.
REQ-003 clk  input  1  logic clock, 250 MHz; all state changes on its rising edge.
REQ-004 rst  input  1  reset; one clock, synchronous, active-high.
REQ-005 TDC_Odata  input  15  echo depth code from tdc_top.
REQ-006 TDC_Oint  input  5  echo intensity count.
REQ-007 TDC_Onum  input  2  valid-data number from tdc_top; captured, not used for selection.
REQ-008 TDC_Olast  input  1  marks the final echo of a measurement.
REQ-009 TDC_Ovalid  input  1  echo beat valid.
REQ-010 TDC_Oready  output  1  this block can accept an echo beat.
REQ-011 cfg_min_int  input  5  intensity threshold; beats with TDC_Oint < cfg_min_int are ineligible.
REQ-012 res_depth  output  15  selected echo depth.
REQ-013 res_int  output  5  selected echo intensity.
REQ-014 res_cnt  output  CNT_W  accepted beats in the frame, saturating.
REQ-015 res_num  output  2  TDC_Onum captured on the last accepted beat.
REQ-016 res_flags  output  2  bit0 no eligible echo, bit1 timeout close.
REQ-017 res_valid  output  1  result record valid.
REQ-018 res_ready  input  1  downstream accepts the result.

Function
REQ-019 A beat is accepted when TDC_Ovalid and TDC_Oready are both 1 on a rising edge.
REQ-020 The FSM states are IDLE, COLLECT and OUTPUT.
REQ-021 TDC_Oready is 1 in IDLE and COLLECT and 0 in OUTPUT.
REQ-022 IDLE -> COLLECT on an accepted beat with TDC_Olast=0; IDLE -> OUTPUT on an accepted beat with TDC_Olast=1.
REQ-023 COLLECT -> OUTPUT on an accepted beat with TDC_Olast=1.
REQ-024 COLLECT -> OUTPUT when the idle counter reaches TIMEOUT; this sets res_flags[1]=1.
REQ-025 OUTPUT -> IDLE on a cycle with res_valid & res_ready; TDC_Oready is 1 in the next cycle.
REQ-026 The idle counter clears on every accepted beat and increments each COLLECT cycle without one.
REQ-027 The first accepted beat of a frame reinitialises the best-echo register, the echo counter and the flags.
REQ-028 The best echo is the eligible beat with the strictly greatest TDC_Oint; on a tie, the earlier beat is kept.
REQ-029 res_cnt counts accepted beats, eligible or not, and holds at 2^CNT_W-1 on overflow.
REQ-030 If no eligible beat occurs in a frame: res_depth=0, res_int=0, res_flags[0]=1.
REQ-031 res_valid rises the cycle after the closing event (last beat accepted, or timeout).
REQ-032 All res_* outputs are registered and hold stable while res_valid=1 and res_ready=0.
REQ-033 The block compares and stores depth codes only; it does not convert them to distance.

Reset
REQ-034 While rst=1, the block enters IDLE on the next edge: TDC_Oready=1, res_valid=0, res_depth=0, res_int=0, res_cnt=0, res_num=0, res_flags=0, counters=0.
REQ-035 A reset during COLLECT or OUTPUT discards the partial frame or pending result; no record is emitted for it.
REQ-036 Beats presented while rst=1 are not accepted.

Verification
REQ-037 Three beats (depth/int = 100/4, 200/9, 300/9 last), cfg_min_int=2, res_ready=1 -> one record: depth 200, int 9, cnt 3, flags 00; res_valid one cycle after the last beat.
REQ-038 Single beat 0x1FFC/3 with last=1, cfg_min_int=5 -> depth 0, int 0, cnt 1, flags 01.
REQ-039 Two beats without last, then 64 idle cycles -> record with flags 10 at cycle 65 after the second beat; TDC_Oready=0 until the record is taken.
REQ-040 Nine beats in one frame with CNT_W=3 -> res_cnt=7; best-intensity selection is still correct.
REQ-041 res_ready=0 for 10 cycles while the next frame's TDC_Ovalid=1 -> outputs stable, no beat accepted; after res_ready=1, the next frame is accepted one cycle later.
REQ-042 rst pulsed for 1 cycle mid-COLLECT -> no record emitted; the next full frame produces a correct record with cnt starting from 1.
